pwr_rst_seq: RTL

Power/reset sequencer for the low-power system. It owns the reset of each power domain and releases them one at a time in fixed ascending order, with a programmed gap and a per-domain ready handshake between releases. It re-runs the sequence on a software reset request and performs an orderly reverse-order shutdown on a power-down request. Each `dom_rst_n` bit drives that domain's local RST_SYNC instance.

---
 rtl/pwr_rst_pkg.sv | 22 ++
 rtl/pwr_rst_wdog.sv | 39 +++
 rtl/pwr_rst_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pwr_rst_pkg.sv
// Shared types and defaults for the power/reset sequencer.
// Covers the sequencer FSM states and the optional ready watchdog.
package pwr_rst_pkg;

    typedef enum logic [2:0] {
        ST_DELAY    = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_RUN      = 3'd2,
        ST_SHUTDOWN = 3'd3,
        ST_OFF      = 3'd4
    } pwr_rst_state_e;

    localparam int PWR_RST_NUM_DOM_DEF = 4;
    localparam int PWR_RST_DLY_DEF     = 16;
    localparam int PWR_RST_ACK_TO_DEF  = 255;

    // Counter width for a modulus n, never narrower than one bit
    function automatic int pwr_rst_cw(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwr_rst_wdog.sv
// Ready-timeout watchdog for the sequencer WAIT_RDY state.
// Counter clears whenever the sequencer is not waiting; error is sticky.
module pwr_rst_wdog
    import pwr_rst_pkg::*;
#(
    parameter int ACK_TO = PWR_RST_ACK_TO_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic rdy,
    output logic timeout,
    output logic seq_err
);

    localparam int TW = pwr_rst_cw(ACK_TO);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TO - 1);

    logic [TW-1:0] tcnt;

    assign timeout = active && !rdy && (tcnt == T_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt    <= '0;
            seq_err <= 1'b0;
        end else begin
            if (!active) begin
                tcnt <= '0;
            end else if (tcnt != T_LAST) begin
                tcnt <= tcnt + 1'b1;
            end
            if (timeout) begin
                seq_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwr_rst_seq.sv
// Power/reset sequencer: ordered domain release, re-sequence, reverse shutdown.
// Define PWR_RST_SEQ_WDOG_EN to build the ready-timeout watchdog.
module pwr_rst_seq
    import pwr_rst_pkg::*;
#(
    parameter int NUM_DOM     = PWR_RST_NUM_DOM_DEF,
    parameter int RELEASE_DLY = PWR_RST_DLY_DEF,
    parameter int ACK_TO      = PWR_RST_ACK_TO_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_rst_req,
    input  logic               pwr_dn_req,
    input  logic [NUM_DOM-1:0] dom_rdy,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               seq_busy,
    output logic               pwr_dn_ack,
    output logic               seq_err
);

    localparam int CW = pwr_rst_cw(RELEASE_DLY);
    localparam int IW = pwr_rst_cw(NUM_DOM);
    localparam logic [CW-1:0] CNT_LAST = CW'(RELEASE_DLY - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOM - 1);

    pwr_rst_state_e state_q, state_d;

    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_DOM-1:0] rst_n_d;
    logic               busy_d, ack_d;
    logic               dly_done, rdy_go, last_dom, timeout;

    assign dly_done = (cnt_q == CNT_LAST);
    assign last_dom = (idx_q == IDX_LAST);
    assign rdy_go   = dom_rdy[idx_q] || timeout;

`ifdef PWR_RST_SEQ_WDOG_EN
    pwr_rst_wdog #(
        .ACK_TO(ACK_TO)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .active (state_q == ST_WAIT_RDY),
        .rdy    (dom_rdy[idx_q]),
        .timeout(timeout),
        .seq_err(seq_err)
    );
`else
    logic unused_ack_to;
    assign unused_ack_to = ^ACK_TO;
    assign timeout       = 1'b0;
    assign seq_err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_DELAY;
            idx_q      <= '0;
            cnt_q      <= '0;
            dom_rst_n  <= '0;
            seq_busy   <= 1'b1;
            pwr_dn_ack <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            dom_rst_n  <= rst_n_d;
            seq_busy   <= busy_d;
            pwr_dn_ack <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_DELAY: begin
                if (dly_done) state_d = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (rdy_go) state_d = last_dom ? ST_RUN : ST_DELAY;
            end
            ST_RUN: begin
                if (sw_rst_req)      state_d = ST_DELAY;
                else if (pwr_dn_req) state_d = ST_SHUTDOWN;
            end
            ST_SHUTDOWN: begin
                if (idx_q == '0) state_d = ST_OFF;
            end
            ST_OFF: begin
                if (!pwr_dn_req) state_d = ST_DELAY;
            end
            default: state_d = ST_DELAY;
        endcase
    end

    // Registered-output next values; flags follow the next state
    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rst_n_d = dom_rst_n;
        unique case (state_q)
            ST_DELAY: begin
                if (dly_done) rst_n_d[idx_q] = 1'b1;
                else          cnt_d = cnt_q + 1'b1;
            end
            ST_WAIT_RDY: begin
                if (rdy_go && !last_dom) begin
                    idx_d = idx_q + 1'b1;
                    cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (sw_rst_req) begin
                    rst_n_d = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (pwr_dn_req) begin
                    idx_d = IDX_LAST;
                end
            end
            ST_SHUTDOWN: begin
                rst_n_d[idx_q] = 1'b0;
                if (idx_q != '0) idx_d = idx_q - 1'b1;
            end
            ST_OFF: begin
                if (!pwr_dn_req) begin
                    idx_d = '0;
                    cnt_d = '0;
                end
            end
            default: begin
                idx_d = '0;
                cnt_d = '0;
            end
        endcase
        busy_d = (state_d != ST_RUN);
        ack_d  = (state_d == ST_OFF);
    end

endmodule
